cv32e41p_apu_responder: RTL and testbench

Responder end of the core's shared APU request/response interface. It accepts operations issued by the core's EX stage on the apu_req/apu_gnt handshake and executes them in a small fixed-latency integer pipeline. Results return in issue order on apu_rvalid/apu_result/apu_flags. It sits outside the core as the reference APU endpoint, used for integration and as the baseline for a later shared FPU.

---
 rtl/cv32e41p_apu_core_pkg.sv | 52 +++++
 rtl/cv32e41p_apu_resp_alu.sv | 76 +++++++
 rtl/cv32e41p_apu_responder.sv | 95 +++++++++
 tb/tb_cv32e41p_apu_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e41p_apu_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e41p_apu_core_pkg
// Description : Shared APU interface widths, latencies, class codes, flag
//               indices and the responder completion-slot entry type.
//               CV32E41P_APU_MAC_EN selects the multiply-add latency.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e41p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  localparam int PIPE_REG_ADDSUB  = 1;
  localparam int PIPE_REG_MULT    = 1;
  localparam int PIPE_REG_CAST    = 1;
  localparam int PIPE_REG_MAC     = 2;

  // Slot entries are sized for the standard 32-bit datapath.
  localparam int APU_WIDTH        = 32;

  localparam logic [1:0] APU_CLS_ADDSUB = 2'b00;
  localparam logic [1:0] APU_CLS_MULT   = 2'b01;
  localparam logic [1:0] APU_CLS_CAST   = 2'b10;
  localparam logic [1:0] APU_CLS_MAC    = 2'b11;

  localparam int APU_FLAG_OVF = 0;
  localparam int APU_FLAG_INV = 4;

  typedef struct packed {
    logic                        valid;
    logic [APU_WIDTH-1:0]        result;
    logic [APU_NUSFLAGS_CPU-1:0] flags;
  } apu_slot_t;

  function automatic int apu_latency(input logic [1:0] cls);
    case (cls)
      APU_CLS_ADDSUB: return PIPE_REG_ADDSUB;
      APU_CLS_MULT:   return PIPE_REG_MULT;
      APU_CLS_CAST:   return PIPE_REG_CAST;
`ifdef CV32E41P_APU_MAC_EN
      default:        return PIPE_REG_MAC;
`else
      default:        return 1;
`endif
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e41p_apu_resp_alu.sv
`default_nettype none
// ============================================================================
// Module      : cv32e41p_apu_resp_alu
// Description : Combinational result/flag generator for the APU responder.
//               Multiply-add built only with CV32E41P_APU_MAC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e41p_apu_resp_alu
  import cv32e41p_apu_core_pkg::*;
#(
  parameter int WIDTH = APU_WIDTH
) (
  input  logic [1:0]                  i_cls,
  input  logic [APU_WOP_CPU-1:0]      i_op,
  input  logic [WIDTH-1:0]            i_a,
  input  logic [WIDTH-1:0]            i_b,
  input  logic [WIDTH-1:0]            i_c,
  output logic [WIDTH-1:0]            o_result,
  output logic [APU_NUSFLAGS_CPU-1:0] o_flags
);

  localparam int C_MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_prod;
  logic             w_unused;

  assign w_sum  = i_a + i_b;
  assign w_dif  = i_a - i_b;
  assign w_prod = i_a * i_b;

`ifdef CV32E41P_APU_MAC_EN
  logic [WIDTH-1:0] w_mac;
  assign w_mac    = w_prod + i_c;
  assign w_unused = ^{i_op[5:2]};
`else
  assign w_unused = ^{i_op[5:2], i_c};
`endif

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    case (i_cls)
      APU_CLS_ADDSUB: begin
        if (i_op[0]) begin
          o_result              = w_dif;
          o_flags[APU_FLAG_OVF] = (i_a[C_MSB] != i_b[C_MSB]) && (w_dif[C_MSB] != i_a[C_MSB]);
        end else begin
          o_result              = w_sum;
          o_flags[APU_FLAG_OVF] = (i_a[C_MSB] == i_b[C_MSB]) && (w_sum[C_MSB] != i_a[C_MSB]);
        end
      end
      APU_CLS_MULT: o_result = w_prod;
      APU_CLS_CAST: begin
        case (i_op[1:0])
          2'b00:   o_result = {{(WIDTH-8){i_a[7]}}, i_a[7:0]};
          2'b01:   o_result = {{(WIDTH-16){i_a[15]}}, i_a[15:0]};
          2'b10:   o_result = {{(WIDTH-16){1'b0}}, i_a[15:0]};
          default: o_result = i_a;
        endcase
      end
      default: begin
`ifdef CV32E41P_APU_MAC_EN
        // Overflow is judged on the final add only; product is taken as wrapped.
        o_result              = w_mac;
        o_flags[APU_FLAG_OVF] = (w_prod[C_MSB] == i_c[C_MSB]) && (w_mac[C_MSB] != w_prod[C_MSB]);
`else
        o_flags[APU_FLAG_INV] = 1'b1;
`endif
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cv32e41p_apu_responder.sv
`default_nettype none
// ============================================================================
// Module      : cv32e41p_apu_responder
// Description : APU responder: req/gnt handshake plus in-order completion
//               slot shift register. CV32E41P_APU_MAC_EN enables the MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e41p_apu_responder
  import cv32e41p_apu_core_pkg::*;
#(
  parameter int WIDTH = APU_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   apu_req_i,
  output logic                                   apu_gnt_o,
  input  logic [APU_NARGS_CPU-1:0][WIDTH-1:0]    apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]                 apu_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]            apu_flags_i,
  output logic                                   apu_rvalid_o,
  output logic [WIDTH-1:0]                       apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]            apu_flags_o
);

`ifdef CV32E41P_APU_MAC_EN
  localparam int C_SLOT_DEPTH = PIPE_REG_MAC;
`else
  localparam int C_SLOT_DEPTH = 1;
`endif

  // Entry k completes k cycles after the current one; entry 0 drives the outputs.
  apu_slot_t [C_SLOT_DEPTH-1:0] r_slot;
  apu_slot_t [C_SLOT_DEPTH-1:0] w_slot_nxt;

  logic [1:0]                  w_cls;
  int                          w_lat;
  logic                        w_block;
  logic                        w_accept;
  logic [WIDTH-1:0]            w_alu_result;
  logic [APU_NUSFLAGS_CPU-1:0] w_alu_flags;
  logic                        w_unused;

  assign w_cls    = apu_op_i[5:4];
  assign w_lat    = apu_latency(w_cls);
  assign w_unused = ^apu_flags_i;

  cv32e41p_apu_resp_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_cls    (w_cls),
    .i_op     (apu_op_i),
    .i_a      (apu_operands_i[0]),
    .i_b      (apu_operands_i[1]),
    .i_c      (apu_operands_i[2]),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // A new op may not share or overtake a completion already scheduled.
  always_comb begin
    w_block = 1'b0;
    for (int k = 1; k < C_SLOT_DEPTH; k++) begin
      if (k >= w_lat) begin
        w_block = w_block | r_slot[k].valid;
      end
    end
  end

  assign apu_gnt_o = apu_req_i & ~w_block;
  assign w_accept  = apu_req_i & apu_gnt_o;

  always_comb begin
    w_slot_nxt = r_slot >> $bits(apu_slot_t);
    for (int k = 0; k < C_SLOT_DEPTH; k++) begin
      if (w_accept && (k == w_lat - 1)) begin
        w_slot_nxt[k] = apu_slot_t'{valid: 1'b1, result: w_alu_result, flags: w_alu_flags};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else begin
      r_slot <= w_slot_nxt;
    end
  end

  // Empty entries always hold zero result and flags.
  assign apu_rvalid_o = r_slot[0].valid;
  assign apu_result_o = r_slot[0].result;
  assign apu_flags_o  = r_slot[0].flags;

endmodule
`default_nettype wire

// File: tb/tb_cv32e41p_apu_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e41p_apu_responder
// Description : Directed plus random stimulus against a completion-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e41p_apu_responder;

`ifdef CV32E41P_APU_MAC_EN
  localparam int MAC_LAT = 2;
`else
  localparam int MAC_LAT = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             apu_req_i;
  logic             apu_gnt_o;
  logic [2:0][31:0] operands;
  logic [5:0]       apu_op_i;
  logic [14:0]      apu_flags_i;
  logic             apu_rvalid_o;
  logic [31:0]      apu_result_o;
  logic [4:0]       apu_flags_o;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   tests;
  int   fails;

  bit          r_req;
  logic [5:0]  r_op;
  logic [31:0] r_a, r_b, r_c;

  cv32e41p_apu_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apu_req_i      (apu_req_i),
    .apu_gnt_o      (apu_gnt_o),
    .apu_operands_i (operands),
    .apu_op_i       (apu_op_i),
    .apu_flags_i    (apu_flags_i),
    .apu_rvalid_o   (apu_rvalid_o),
    .apu_result_o   (apu_result_o),
    .apu_flags_o    (apu_flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input logic [5:0] op);
    return (op[5:4] == 2'b11) ? MAC_LAT : 1;
  endfunction

  function automatic void ref_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, output logic [31:0] r, output logic [4:0] f);
    longint          sa;
    longint          sb;
    longint          full;
    longint unsigned pu;
    logic [31:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    pu = 64'(a) * 64'(b);
    p  = pu[31:0];
    r  = 32'h0;
    f  = 5'h0;
    case (op[5:4])
      2'b00: begin
        full = op[0] ? (sa - sb) : (sa + sb);
        r    = full[31:0];
        f[0] = (full[63:31] != {33{full[31]}});
      end
      2'b01: r = p;
      2'b10: begin
        case (op[1:0])
          2'b00:   r = int'($signed(a[7:0]));
          2'b01:   r = int'($signed(a[15:0]));
          2'b10:   r = {16'h0, a[15:0]};
          default: r = a;
        endcase
      end
      default: begin
`ifdef CV32E41P_APU_MAC_EN
        full = longint'($signed(p)) + longint'($signed(c));
        r    = full[31:0];
        f[0] = (full[63:31] != {33{full[31]}});
`else
        f[4] = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check gnt and outputs, then model the edge.
  task automatic step(input bit req, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    logic [4:0]  f;
    bit          eg;
    bit          ev;
    exp_t        e;
    apu_req_i   = req;
    apu_op_i    = op;
    operands[0] = a;
    operands[1] = b;
    operands[2] = c;
    apu_flags_i = 15'($urandom);
    #1;
    eg = req;
    foreach (q[i]) if (q[i].due >= cyc + lat(op)) eg = 1'b0;
    chk("gnt", {31'h0, apu_gnt_o}, {31'h0, eg});
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("rvalid", {31'h0, apu_rvalid_o}, {31'h0, ev});
    chk("result", apu_result_o, ev ? q[0].res : 32'h0);
    chk("flags", {27'h0, apu_flags_o}, ev ? {27'h0, q[0].flg} : 32'h0);
    if (ev) void'(q.pop_front());
    ref_op(op, a, b, c, r, f);
    @(posedge clk);
    if (req && eg) begin
      e.due = cyc + lat(op);
      e.res = r;
      e.flg = f;
      q.push_back(e);
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 6'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic reset_step(input bit req);
    rst_n     = 1'b0;
    apu_req_i = req;
    apu_op_i  = 6'($urandom);
    #1;
    q.delete();
    chk("rst_gnt", {31'h0, apu_gnt_o}, {31'h0, req});
    chk("rst_rvalid", {31'h0, apu_rvalid_o}, 32'h0);
    chk("rst_result", apu_result_o, 32'h0);
    chk("rst_flags", {27'h0, apu_flags_o}, 32'h0);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    apu_req_i   = 1'b0;
    apu_op_i    = 6'h0;
    operands    = '0;
    apu_flags_i = 15'h0;
    @(posedge clk);
    #1;
    reset_step(1'b1);
    reset_step(1'b0);
    rst_n = 1'b1;

    // ADDSUB overflow
    step(1'b1, 6'h00, 32'h7FFFFFFF, 32'h1, 32'h0);
    idle();
    // MULT stream
    step(1'b1, 6'h10, 32'd3, 32'd5, 32'h0);
    step(1'b1, 6'h10, 32'hFFFFFFFF, 32'd2, 32'h0);
    idle();
    idle();
    // MAC followed by ADDSUB held off for one cycle
    step(1'b1, 6'h30, 32'd2, 32'd3, 32'd4);
    step(1'b1, 6'h00, 32'd1, 32'd1, 32'h0);
    step(1'b1, 6'h00, 32'd1, 32'd1, 32'h0);
    idle();
    idle();
    // CAST variants
    step(1'b1, 6'h20, 32'h000080F0, 32'h0, 32'h0);
    step(1'b1, 6'h21, 32'h000080F0, 32'h0, 32'h0);
    step(1'b1, 6'h22, 32'h000080F0, 32'h0, 32'h0);
    step(1'b1, 6'h23, 32'h000080F0, 32'h0, 32'h0);
    idle();
    // Reset while a MAC is in flight
    step(1'b1, 6'h30, 32'd2, 32'd3, 32'd4);
    reset_step(1'b1);
    rst_n = 1'b1;
    step(1'b1, 6'h01, 32'd5, 32'd6, 32'h0);
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      r_req = ($urandom_range(0, 9) < 7);
      r_op  = 6'($urandom);
      r_a   = pick();
      r_b   = pick();
      r_c   = pick();
      step(r_req, r_op, r_a, r_b, r_c);
    end
    for (int i = 0; i < 4; i++) idle();
    chk("drain", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
